encrypt_engine: RTL and testbench
=================================

# encrypt_engine

AES-128 encryption engine: a fully pipelined, one-block-per-cycle cipher datapath with an on-chip sequential key expander. A key is loaded once with `set_key` and expanded into per-round key registers. Plaintext blocks are then streamed in with `start`, and ciphertext emerges after a fixed latency. It sits between the accelerator's host/control interface and its output buffer.

## Interface
Parameters: none (fixed AES-128, 10 rounds).

- `clk  input  1` — single clock; all state updates on the rising edge.
- `rst  input  1` — one clock; reset is synchronous and active-high.
- `start  input  1` — valid strobe for `state`; one block is accepted per cycle while high and the engine is READY.
- `set_key  input  1` — load `key` and begin key expansion.
- `halt  input  1` — abort: flush the pipeline and cancel expansion.
- `state  input  128` — plaintext block, FIPS-197 byte order (bits [127:120] = byte 0).
- `key  input  128` — cipher key, same byte order.
- `out  output  128` — ciphertext block.
- `out_valid  output  1` — `out` holds a new ciphertext this cycle.

## Operation
- Internal storage:
  - `key0` register (round key 0).
  - `stage_key_regs[0..9]` hold round keys 1..10.
  - Pipeline registers P0 (after the initial AddRoundKey), P1..P9 (after rounds 1..9), then `out` (after round 10). Each has a valid bit.
- Key-expansion FSM `fsm_state`:
  - IDLE=0: no valid keys.
  - KEYGEN=1: expansion in progress.
  - READY=2: all keys valid.
- `key_gen_idx` is 4 bits, range 0..9.
- Transitions:
  - Any state, `set_key`=1 (and `halt`=0): `key0`←`key`, `key_gen_idx`←0, go to KEYGEN, clear all pipeline valid bits.
  - KEYGEN: each cycle, `stage_key_regs[idx]` ← expand(previous round key, rcon[idx+1]). Previous key is `key0` when idx=0, else `stage_key_regs[idx-1]`. Then idx++.
  - KEYGEN, idx=9: write the final key and go to READY.
- Key expansion, one combinational step:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon. Rcon sequence: 01,02,04,08,10,20,40,80,1b,36 in the top byte.
  - w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- Data path:
  - A block is accepted only when `start`=1 and fsm=READY and `halt`=0 and `set_key`=0. Blocks offered otherwise are dropped; there is no back-pressure.
  - P0 ← `state` ^ `key0`.
  - Pk (k = 1..9) ← MixColumns(ShiftRows(SubBytes(Pk-1))) ^ round key k.
  - `out` ← ShiftRows(SubBytes(P9)) ^ round key 10.
  - Valid bits shift alongside the data each cycle.
- `out` updates only when the incoming final-stage valid bit is 1; otherwise it holds its last value. `out_valid` follows the final-stage valid bit.
- `halt`=1: clear every pipeline valid bit and `out_valid` next edge.
  - If in KEYGEN, return to IDLE.
  - If in READY, stay READY with keys retained.
  - `halt` has priority over `set_key` and `start`.
- `rst`:
  - FSM→IDLE, `key_gen_idx`=0, all valid bits 0.
  - `out`=0, `out_valid`=0, `key0` and `stage_key_regs` = 0.
  - Reset asserted mid-operation discards all in-flight blocks and keys.
- S-box is combinational; 16 instances per round stage plus 4 for the key expander.

## Timing
- `set_key` sampled at edge S ⇒ fsm=KEYGEN after S.
  - Round key i (1..10) is written at edge S+i.
  - fsm=READY after S+10.
  - The first block can be accepted at edge S+11.
- Block accepted at edge E ⇒ `out`/`out_valid` are updated at edge E+10. Latency is 11 registers (P0..P9, `out`).
- Throughput: one block per cycle; consecutive accepts yield consecutive `out_valid` cycles in the same order.
- `out_valid` is high for exactly one cycle per accepted block.
- The pipeline drains normally when `start` drops.

## Test plan
- Reset, then idle 5 cycles ⇒ `out`=0, `out_valid`=0, fsm=IDLE.
- Key expansion:
  - Stimulus: `set_key` pulse with `key`=000102030405060708090a0b0c0d0e0f.
  - After 10 cycles: fsm=READY, `stage_key_regs[0]`=d6aa74fdd2af72fadaa678f1d6ab76fe, `stage_key_regs[9]`=13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 vector:
  - Stimulus: after READY, one-cycle `start` with `state`=00112233445566778899aabbccddeeff.
  - Response: 10 edges later `out`=69c4e0d86a7b0430d8cdb78070b4c55a with `out_valid`=1 for one cycle.
- Streaming:
  - Stimulus: `start` held for 3 cycles with distinct plaintexts, including the all-zero block under the all-zero key.
  - Response: 3 consecutive valid outputs in order; the zero/zero case gives 66e94bd4ef8a2c3b884cfa59ca342b2e.
- `start` during KEYGEN ⇒ ignored, no `out_valid` ever produced. `start` asserted before `set_key` ⇒ ignored.
- Halt:
  - `halt` with 4 blocks in flight ⇒ no `out_valid` afterwards.
  - Keys are kept: a new block then encrypts correctly.
  - `halt` during KEYGEN ⇒ fsm=IDLE.

Source files
------------

// File: rtl/encrypt_engine.sv
// AES-128 encryption engine: sequential on-chip key expander feeding a fully
// unrolled 10-round pipeline that accepts one plaintext block per cycle.
module encrypt_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         set_key,
  input  logic         halt,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         out_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYGEN = 2'd1,
    READY  = 2'd2
  } fsm_state_t;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TABLE[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
  function automatic logic [127:0] sub_shift(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[127 - 8*(rr + 4*c) -: 8] = sbox(b[127 - 8*(rr + 4*((c + rr) % 4)) -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] b);
    logic [127:0] r;
    logic [31:0]  col;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      col = b[127 - 32*c -: 32];
      a0  = col[31:24];
      a1  = col[23:16];
      a2  = col[15:8];
      a3  = col[7:0];
      r[127 - 32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsm_state_t   fsm_state_q;
  logic [3:0]   key_gen_idx_q;
  logic [127:0] key0_q;
  logic [127:0] stage_key_regs_q [10];
  logic [127:0] prev_key_d;
  logic [127:0] next_key_d;

  always_comb begin
    prev_key_d = key0_q;
    for (int i = 1; i < 10; i++) begin
      if (key_gen_idx_q == 4'(i)) prev_key_d = stage_key_regs_q[i-1];
    end
    next_key_d = key_step(prev_key_d, rcon(key_gen_idx_q));
  end

  // Halt outranks set_key; a halted READY engine keeps its schedule.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_state_q   <= IDLE;
      key_gen_idx_q <= '0;
      key0_q        <= '0;
      for (int i = 0; i < 10; i++) stage_key_regs_q[i] <= '0;
    end else if (halt) begin
      if (fsm_state_q == KEYGEN) begin
        fsm_state_q   <= IDLE;
        key_gen_idx_q <= '0;
      end
    end else if (set_key) begin
      key0_q        <= key;
      key_gen_idx_q <= '0;
      fsm_state_q   <= KEYGEN;
    end else if (fsm_state_q == KEYGEN) begin
      for (int i = 0; i < 10; i++) begin
        if (key_gen_idx_q == 4'(i)) stage_key_regs_q[i] <= next_key_d;
      end
      if (key_gen_idx_q == 4'd9) begin
        fsm_state_q   <= READY;
        key_gen_idx_q <= '0;
      end else begin
        key_gen_idx_q <= key_gen_idx_q + 4'd1;
      end
    end
  end

  logic         accept;
  logic         flush;
  logic [127:0] pipe_q [10];
  logic [127:0] pipe_d [10];
  logic [9:0]   pipe_valid_q;
  logic [9:0]   pipe_valid_d;
  logic [127:0] final_d;
  logic [127:0] out_q;
  logic [127:0] out_d;
  logic         out_valid_q;
  logic         out_valid_d;

  assign accept = start && (fsm_state_q == READY) && !halt && !set_key;
  assign flush  = halt || set_key;

  assign pipe_d[0] = state ^ key0_q;

  generate
    for (genvar gi = 1; gi < 10; gi++) begin : g_round
      assign pipe_d[gi] = mix_columns(sub_shift(pipe_q[gi-1])) ^ stage_key_regs_q[gi-1];
    end
  endgenerate

  assign final_d = sub_shift(pipe_q[9]) ^ stage_key_regs_q[9];

  always_comb begin
    pipe_valid_d = flush ? 10'd0 : {pipe_valid_q[8:0], accept};
    out_valid_d  = !flush && pipe_valid_q[9];
    out_d        = out_q;
    if (out_valid_d) out_d = final_d;
  end

  // Data registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 10; i++) pipe_q[i] <= pipe_d[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_q <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_encrypt_engine.sv
// Bench for encrypt_engine: known-answer AES-128 vectors through a scoreboard,
// plus key-schedule, latency, halt and ignored-start sequences.
module tb_encrypt_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         set_key;
  logic         halt;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;
  logic         out_valid;

  always #5 clk = ~clk;

  encrypt_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .set_key   (set_key),
    .halt      (halt),
    .state     (state),
    .key       (key),
    .out       (out),
    .out_valid (out_valid)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t         vecs [5];
  logic [127:0] exp_q [$];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [1:0] fsm_now();
    logic [1:0] f;
    f = dut.fsm_state_q;
    return f;
  endfunction

  // Advance one clock and let the scoreboard judge any output it sees.
  task automatic tick();
    logic [127:0] e;
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out=%h expected no output", out);
      end else begin
        e = exp_q.pop_front();
        check("ciphertext", out, e);
      end
    end
  endtask

  task automatic load_key(input logic [127:0] k, input bit noise);
    set_key = 1'b1;
    key     = k;
    tick();
    set_key = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = noise;
      state = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    start = 1'b0;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] ct);
    state = pt;
    start = 1'b1;
    exp_q.push_back(ct);
    tick();
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[3] = '{128'h0, 128'hf34481ec3cc627bacd5dc3fb08f273e6, 128'h0336763e966d92595a567cc9ce537f5e};
    vecs[4] = '{128'h0, 128'h9798c4640bad75c7c3227db910174e72, 128'ha9a1631bf4996954ebc093957b234589};

    rst = 1'b1; start = 1'b0; set_key = 1'b0; halt = 1'b0; state = '0; key = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Start offered before any key exists must vanish.
    start = 1'b1;
    state = 128'hdeadbeef;
    tick();
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("reset_out", out, 128'h0);
    check("reset_out_valid", {127'b0, out_valid}, 128'h0);
    check("reset_fsm_idle", {126'b0, fsm_now()}, 128'd0);

    // Key expansion, with start toggling during KEYGEN.
    load_key(vecs[0].key, 1'b1);
    check("keygen_ready", {126'b0, fsm_now()}, 128'd2);
    check("round_key_1", dut.stage_key_regs_q[0], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check("round_key_10", dut.stage_key_regs_q[9], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // FIPS-197 vector with exact latency.
    send(vecs[0].pt, vecs[0].ct);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 9)  check("latency_not_early", {127'b0, out_valid}, 128'd0);
      if (i == 10) check("latency_valid_at_10", {127'b0, out_valid}, 128'd1);
    end
    tick();
    check("out_valid_one_cycle", {127'b0, out_valid}, 128'd0);

    load_key(vecs[1].key, 1'b0);
    send(vecs[1].pt, vecs[1].ct);
    repeat (11) tick();

    // Three back-to-back blocks under the all-zero key.
    load_key(128'h0, 1'b0);
    for (int i = 2; i < 5; i++) begin
      state = vecs[i].pt;
      start = 1'b1;
      exp_q.push_back(vecs[i].ct);
      tick();
    end
    start = 1'b0;
    repeat (12) tick();
    check("stream_drained", 128'(exp_q.size()), 128'd0);

    // Halt with four blocks in flight: none of them may emerge.
    for (int i = 0; i < 4; i++) begin
      state = {$urandom, $urandom, $urandom, $urandom};
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    halt  = 1'b1;
    tick();
    halt  = 1'b0;
    repeat (14) tick();
    check("halt_keeps_ready", {126'b0, fsm_now()}, 128'd2);
    send(vecs[3].pt, vecs[3].ct);
    repeat (11) tick();

    // Halt during KEYGEN returns to IDLE; a later start is ignored.
    set_key = 1'b1;
    key     = vecs[1].key;
    tick();
    set_key = 1'b0;
    repeat (3) tick();
    check("keygen_state", {126'b0, fsm_now()}, 128'd1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_keygen_idle", {126'b0, fsm_now()}, 128'd0);
    state = vecs[1].pt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
